// File: rtl/digit_serial_multiplier_pkg.sv
// Shared definitions for the digit-serial multiplier: digit width, FSM
// state encoding and the digit-pair count helper.
package digit_serial_multiplier_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digit pairs (= RUN cycles) for a w-bit operand.
  function automatic int num_pairs(input int w);
    return (w / DIGIT_W) * (w / DIGIT_W);
  endfunction

endpackage

// File: rtl/digit_serial_multiplier_mul_digit_2x2.sv
// Combinational 2-bit x 2-bit unsigned digit product (max 3*3 = 9).
module mul_digit_2x2
  import digit_serial_multiplier_pkg::*;
(
  input  logic [DIGIT_W-1:0]   a,
  input  logic [DIGIT_W-1:0]   b,
  output logic [2*DIGIT_W-1:0] p
);

  // Zero-extend both digits so the product keeps all four bits.
  always_comb begin
    p = {{DIGIT_W{1'b0}}, a} * {{DIGIT_W{1'b0}}, b};
  end

endmodule

// File: rtl/digit_serial_multiplier.sv
// Sequential unsigned W x W digit-serial multiplier.
// One 2-bit digit pair per RUN cycle is multiplied, shifted into place and
// accumulated into a 2W-bit product. A saturated W-bit Q-format result with
// FRAC fraction bits is formed alongside the full product.
// Optional macro MUL_ROUND_EN: round-half-up the Q result instead of
// truncating (the full product P is never rounded).
module digit_serial_multiplier
  import digit_serial_multiplier_pkg::*;
#(
  parameter int W    = 8,
  parameter int FRAC = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [2*W-1:0] P,
  output logic [W-1:0]   Q,
  output logic           ovf,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam int NDIG = W / DIGIT_W;
  localparam int CW   = $clog2(NDIG);
  localparam int N    = num_pairs(W);
  localparam int PW   = $clog2(N);

  localparam logic [CW-1:0] LAST_DIG  = CW'(NDIG - 1);
  localparam logic [PW-1:0] LAST_PAIR = PW'(N - 1);

  // Rounding constant for the Q slice; kept at zero when there are no
  // fraction bits so the shift amount never goes negative.
  localparam int            RND_SH = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic [2*W:0]  RND    = (FRAC > 0) ? ((2*W+1)'(1) << RND_SH) : '0;

  state_t state, state_nxt;

  logic [W-1:0]           a_q, b_q;
  logic [2*W-1:0]         acc, acc_nxt, term;
  logic [CW-1:0]          i_q, j_q;
  logic [PW-1:0]          pair_cnt;
  logic [CW+1:0]          shamt;
  logic [DIGIT_W-1:0]     a_dig, b_dig;
  logic [2*DIGIT_W-1:0]   dprod;
  logic                   accept, last_pair;
  logic [2*W:0]           r;
  logic [W-1:0]           q_nxt;
  logic                   ovf_nxt;

  // Current digit pair: i walks A's digits (inner), j walks B's digits.
  always_comb begin
    a_dig = a_q[DIGIT_W*i_q +: DIGIT_W];
    b_dig = b_q[DIGIT_W*j_q +: DIGIT_W];
  end

  mul_digit_2x2 u_digit (
    .a (a_dig),
    .b (b_dig),
    .p (dprod)
  );

  // Weight the digit product by 4^(i+j) and add it to the running sum.
  // The sum of indices is widened so 2*(i+j) cannot wrap.
  always_comb begin
    shamt   = ({2'b00, i_q} + {2'b00, j_q}) << 1;
    term    = (2*W)'(dprod) << shamt;
    acc_nxt = acc + term;
  end

  // Q/ovf from the final sum: anything above bit FRAC+W-1 saturates.
  always_comb begin
    r = {1'b0, acc_nxt};
`ifdef MUL_ROUND_EN
    r = r + RND;
`endif
    ovf_nxt = |(r >> (FRAC + W));
    q_nxt   = ovf_nxt ? {W{1'b1}} : r[FRAC +: W];
  end

  assign last_pair = (pair_cnt == LAST_PAIR);
  assign accept    = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and handshake outputs; new operands are taken only in IDLE,
  // which leaves one bubble after every DONE handshake.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_pair) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, digit sequencing, accumulation and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      pair_cnt <= '0;
      P        <= '0;
      Q        <= '0;
      ovf      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_q      <= A;
            b_q      <= B;
            acc      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            pair_cnt <= '0;
          end
        end
        RUN: begin
          acc      <= acc_nxt;
          pair_cnt <= pair_cnt + 1'b1;
          if (i_q == LAST_DIG) begin
            i_q <= '0;
            j_q <= j_q + 1'b1;
          end else begin
            i_q <= i_q + 1'b1;
          end
          if (last_pair) begin
            P   <= acc_nxt;
            Q   <= q_nxt;
            ovf <= ovf_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_multiplier.sv
// Directed bench for digit_serial_multiplier at W=8, FRAC=4 with a result
// scoreboard. Q expectations follow MUL_ROUND_EN when it is defined.
module tb_digit_serial_multiplier;

  localparam int W    = 8;
  localparam int FRAC = 4;
  localparam int N    = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  A, B;
  logic          in_valid, out_ready;
  logic          in_ready, ovf, out_valid;
  logic [2*W-1:0] P;
  logic [W-1:0]  Q;

  digit_serial_multiplier #(.W(W), .FRAC(FRAC)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .P         (P),
    .Q         (Q),
    .ovf       (ovf),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] p;
    logic [7:0]  q;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic [15:0] p, input logic [7:0] q, input logic o);
    exp_t e;
    e.p = p; e.q = q; e.ovf = o;
    return e;
  endfunction

  // Reference arithmetic for the non-directed operand pairs.
  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    logic [16:0] r;
    e.p = 16'(a) * 16'(b);
    r   = {1'b0, e.p};
`ifdef MUL_ROUND_EN
    r = r + 17'd8;
`endif
    e.ovf = (r >> 12) != 17'd0;
    e.q   = e.ovf ? 8'hFF : r[11:4];
    return e;
  endfunction

  // Present operands in IDLE and return just after the accept edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b,
                          input bit push, input exp_t e);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    A = a; B = b; in_valid = 1'b1;
    if (push) sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
  endtask

  // Count edges from accept to out_valid, then compare with the scoreboard.
  task automatic wait_result();
    int   cnt = 0;
    bit   seen = 1'b0;
    exp_t e;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      check("in_ready_run", 32'(in_ready), 32'd0);
      @(posedge clk);
      cnt++;
    end
    check("out_valid_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("latency", 32'(cnt), 32'(N));
      check("in_ready_done", 32'(in_ready), 32'd0);
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("P", 32'(P), 32'(e.p));
        check("Q", 32'(Q), 32'(e.q));
        check("ovf", 32'(ovf), 32'(e.ovf));
      end
    end
  endtask

  // Handshake the result and confirm the return to IDLE.
  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", 32'(out_valid), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] p_hold;
    logic [7:0]  q_hold;
    bit          saw_valid;
    exp_t        none;
    none = '0;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_P", 32'(P), 32'd0);
    check("rst_Q", 32'(Q), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // Small product with out_ready already high.
    out_ready = 1'b1;
    start_op(8'h03, 8'h03, 1'b1, mk(16'h0009, 8'h00, 1'b0));
    wait_result();
    finish_op();

    // Saturation, then zero operand.
    start_op(8'hFF, 8'hFF, 1'b1, mk(16'hFE01, 8'hFF, 1'b1));
    wait_result();
    finish_op();
    start_op(8'h00, 8'hA5, 1'b1, mk(16'h0000, 8'h00, 1'b0));
    wait_result();
    finish_op();

    // 1.5 * 1.5 is exact, so rounding does not change Q.
    start_op(8'h18, 8'h18, 1'b1, mk(16'h0240, 8'h24, 1'b0));
    wait_result();
    finish_op();

    // Backpressure: result held while a new request waits.
`ifdef MUL_ROUND_EN
    start_op(8'h13, 8'h13, 1'b1, mk(16'h0169, 8'h17, 1'b0));
`else
    start_op(8'h13, 8'h13, 1'b1, mk(16'h0169, 8'h16, 1'b0));
`endif
    wait_result();
    p_hold = P; q_hold = Q;
    A = 8'h21; B = 8'h07; in_valid = 1'b1;
    sb.push_back(model(8'h21, 8'h07));
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_P_stable", 32'(P), 32'h0169);
      check("bp_P_hold", 32'(P), 32'(p_hold));
      check("bp_Q_hold", 32'(Q), 32'(q_hold));
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_drop", 32'(out_valid), 32'd0);
    check("bp_bubble", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = 8'h5A; B = 8'hC3;
    @(negedge clk);
    check("bp_accept", 32'(in_ready), 32'd0);
    // wait_result counts from the accept edge; one edge has elapsed here,
    // so compensate by waiting out the remaining RUN cycles directly.
    saw_valid = 1'b0;
    for (int k = 1; k < N; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("bp_no_early_valid", 32'(saw_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("bp_valid_at_N", 32'(out_valid), 32'd1);
    if (sb.size() > 0) begin
      none = sb.pop_front();
      check("bp_P2", 32'(P), 32'(none.p));
      check("bp_Q2", 32'(Q), 32'(none.q));
      check("bp_ovf2", 32'(ovf), 32'(none.ovf));
    end
    finish_op();

    // Abort with reset at RUN cycle 7.
    start_op(8'hFF, 8'hFF, 1'b0, none);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_P", 32'(P), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    saw_valid = 1'b0;
    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("abort_no_valid", 32'(saw_valid), 32'd0);
    start_op(8'h02, 8'h05, 1'b1, mk(16'h000A, 8'h00, 1'b0));
    wait_result();
    finish_op();

    // A few random operand pairs against the reference arithmetic.
    for (int t = 0; t < 4; t++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = 8'($urandom);
      start_op(ra, rb, 1'b1, model(ra, rb));
      wait_result();
      finish_op();
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
